ex_alu_stage: RTL

- Execute stage of the 5-stage RISC-V pipeline; sits directly downstream of the ALU control decoder and consumes its 4-bit aluctl code.
- Selects operands through the forwarding muxes and the immediate mux, then computes the ALU result and zero flag.
- Registers the result, store data and MEM/WB control bits into the EX/MEM pipeline register, with stall and flush.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 28 ++
 rtl/ex_alu_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes, forward-select codes and the EX/MEM control bundle.
package alu_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b1100;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } mem_ctl_t;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and zero flag from two operands and the aluctl code.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      aluctl,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    always_comb begin
        result = '0;
        case (aluctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SLL: result = a << b[SHAMT_W-1:0];
            ALU_SUB: result = a - b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: operand forwarding/immediate muxes, ALU, and the EX/MEM register
// with reset > flush > stall > load priority.
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [3:0]      aluctl,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            alusrc,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic [4:0]      rd_in,
    input  logic            regwrite_in,
    input  logic            memread_in,
    input  logic            memwrite_in,
    input  logic            memtoreg_in,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_zero,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_aluresult,
    output logic            mem_zero,
    output logic [XLEN-1:0] mem_storedata,
    output logic [4:0]      mem_rd,
    output logic            mem_regwrite,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic            mem_memtoreg
);
    logic [XLEN-1:0] op_a, rs2_fwd, op_b, result;
    mem_ctl_t        ctl_in, ctl_q;

    // Select code 2'b11 falls through to the register-file value.
    always_comb begin
        op_a = rs1_data;
        case (fwd_a)
            FWD_WB:  op_a = wb_fwd_data;
            FWD_MEM: op_a = mem_fwd_data;
            default: op_a = rs1_data;
        endcase
        rs2_fwd = rs2_data;
        case (fwd_b)
            FWD_WB:  rs2_fwd = wb_fwd_data;
            FWD_MEM: rs2_fwd = mem_fwd_data;
            default: rs2_fwd = rs2_data;
        endcase
    end

    assign op_b = alusrc ? imm : rs2_fwd;

    alu_core #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .aluctl (aluctl),
        .result (result),
        .zero   (ex_zero)
    );

    // Bubbles carry no side effects downstream: control bits gated by ex_valid.
    assign ctl_in = ex_valid ? mem_ctl_t'({regwrite_in, memread_in, memwrite_in, memtoreg_in})
                             : mem_ctl_t'('0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_valid     <= 1'b0;
            mem_aluresult <= '0;
            mem_zero      <= 1'b0;
            mem_storedata <= '0;
            mem_rd        <= '0;
            ctl_q         <= '0;
        end else if (!stall) begin
            mem_valid     <= ex_valid;
            mem_aluresult <= result;
            mem_zero      <= ex_zero;
            mem_storedata <= rs2_fwd;
            mem_rd        <= rd_in;
            ctl_q         <= ctl_in;
        end
    end

    assign mem_regwrite = ctl_q.regwrite;
    assign mem_memread  = ctl_q.memread;
    assign mem_memwrite = ctl_q.memwrite;
    assign mem_memtoreg = ctl_q.memtoreg;
endmodule
